// File: rtl/exec_ctrl_seq_if.sv
// Bundle between the instruction sequencer, its instruction/result clients
// and the downstream exec_unit. "master" is the sequencer's own view;
// "slave" is the view of the surrounding environment.
interface exec_ctrl_seq_if #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int FW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic          ld;
  logic          write;
  logic          en_alu;
  logic          en_mem;
  logic [AW-1:0] addr;
  logic [DW-1:0] indata;
  logic [FW-1:0] f_select;
  logic [DW-1:0] outdata;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          illegal;
  logic          busy;

  modport master (
    input  instr_valid, instr, outdata, res_ready,
    output instr_ready, ld, write, en_alu, en_mem, addr, indata, f_select,
           res_valid, res_data, illegal, busy
  );

  modport slave (
    output instr_valid, instr, outdata, res_ready,
    input  instr_ready, ld, write, en_alu, en_mem, addr, indata, f_select,
           res_valid, res_data, illegal, busy
  );
endinterface

// File: rtl/exec_ctrl_seq.sv
// Instruction sequencer in front of exec_unit. Accepts one 16-bit instruction
// in IDLE, drives the exec_unit strobes for HOLD_CYCLES cycles, then inserts
// a one-cycle gap (GAP) or a result-handshake phase (RESP, for reads).
module exec_ctrl_seq #(
  parameter int DW          = 8,
  parameter int AW          = 3,
  parameter int FW          = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_ctrl_seq_if.master bus
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OPC_NOP = 3'b000,
    OPC_LDI = 3'b001,
    OPC_ALU = 3'b010,
    OPC_RD  = 3'b011
  } opc_t;

  state_t        r_state;
  state_t        w_state_nxt;
  opc_t          r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_imm;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_res_data;
  logic          r_illegal;

  logic [2:0]    w_opc;
  logic          w_ready;
  logic          w_accept;
  logic          w_exec;
  logic          w_last_drive;

  assign w_opc        = bus.instr[15:13];
  assign w_ready      = rst_n && (r_state == IDLE);
  assign w_accept     = bus.instr_valid && w_ready;
  assign w_exec       = (w_opc == OPC_LDI) || (w_opc == OPC_ALU) || (w_opc == OPC_RD);
  assign w_last_drive = (r_state == DRIVE) && (r_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and exec_unit / handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    bus.ld          = 1'b0;
    bus.write       = 1'b0;
    bus.en_alu      = 1'b0;
    bus.en_mem      = 1'b0;
    bus.addr        = '0;
    bus.indata      = '0;
    bus.f_select    = '0;
    bus.res_valid   = 1'b0;
    bus.res_data    = r_res_data;
    bus.illegal     = r_illegal;
    bus.busy        = (r_state != IDLE);
    bus.instr_ready = w_ready;

    case (r_state)
      IDLE: begin
        if (w_accept && w_exec) w_state_nxt = DRIVE;
      end
      DRIVE: begin
        bus.addr = r_addr;
        case (r_op)
          OPC_LDI: begin
            bus.ld     = 1'b1;
            bus.write  = 1'b1;
            bus.en_mem = 1'b1;
            bus.indata = r_imm;
          end
          OPC_ALU: begin
            bus.en_alu   = 1'b1;
            bus.f_select = r_imm[FW-1:0];
          end
          OPC_RD: begin
            bus.en_mem = 1'b1;
          end
          default: bus.addr = '0;
        endcase
        if (r_cnt == '0) w_state_nxt = (r_op == OPC_RD) ? RESP : GAP;
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decoded-field capture and DRIVE window down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OPC_NOP;
      r_addr <= '0;
      r_imm  <= '0;
      r_cnt  <= '0;
    end else if (w_accept && w_exec) begin
      r_op   <= opc_t'(w_opc);
      r_addr <= AW'(bus.instr[12:10]);
      r_imm  <= DW'(bus.instr[7:0]);
      r_cnt  <= CW'(HOLD_CYCLES - 1);
    end else if ((r_state == DRIVE) && (r_cnt != '0)) begin
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  // Read data captured at the edge that ends the last DRIVE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_res_data <= '0;
    else if (w_last_drive && r_op == OPC_RD) r_res_data <= bus.outdata;
  end

  // One-cycle pulse for a dropped illegal opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else        r_illegal <= w_accept && w_opc[2];
  end

endmodule

// File: tb/tb_exec_ctrl_seq.sv
// Self-checking bench for exec_ctrl_seq: directed scenarios plus randomized
// instruction streams checked against a cycle-timeline reference model.
module tb_exec_ctrl_seq;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FW = 3;
  localparam int H  = 2;
  localparam int VW = 4 + AW + DW + FW;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  exec_ctrl_seq_if #(.DW(DW), .AW(AW), .FW(FW)) bus ();

  exec_ctrl_seq #(.DW(DW), .AW(AW), .FW(FW), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected exec_unit bundle {ld,write,en_alu,en_mem,addr,indata,f_select}
  // while an instruction's strobe window is active.
  function automatic logic [VW-1:0] exp_vec(input logic [15:0] ins);
    logic [AW-1:0] a;
    logic [DW-1:0] imm;
    a   = ins[12:10];
    imm = ins[7:0];
    case (ins[15:13])
      3'b001:  return {4'b1101, a, imm, {FW{1'b0}}};
      3'b010:  return {4'b0010, a, {DW{1'b0}}, imm[FW-1:0]};
      3'b011:  return {4'b0001, a, {DW{1'b0}}, {FW{1'b0}}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.ld, bus.write, bus.en_alu, bus.en_mem, bus.addr, bus.indata, bus.f_select};
  endfunction

  // Runs one instruction from IDLE back to IDLE, checking every cycle.
  task automatic exec_one(input logic [15:0] ins, input int unsigned rwait,
                          input int od, input bit hold, input string tag);
    logic [VW-1:0] ev;
    logic [2:0]    op;
    logic [DW-1:0] rd_val;
    op     = ins[15:13];
    ev     = exp_vec(ins);
    rd_val = '0;
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_start act=%b exp=1", tag, bus.instr_ready); end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.res_ready   = 1'b0;
    tick();
    if (op == 3'b000 || op[2]) begin
      bus.instr_valid = 1'b0;
      n_tests++; if (bus.illegal !== op[2]) begin n_fail++; $display("FAIL %s illegal_pulse act=%b exp=%b", tag, bus.illegal, op[2]); end
      n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL %s strobes_nop act=%h exp=0", tag, act_vec()); end
      n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_nop act=%b exp=1", tag, bus.instr_ready); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_nop act=%b exp=0", tag, bus.busy); end
      tick();
      n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL %s illegal_end act=%b exp=0", tag, bus.illegal); end
      return;
    end
    if (hold) bus.instr = 16'($urandom());
    else      bus.instr_valid = 1'b0;
    for (int unsigned k = 1; k <= H; k++) begin
      n_tests++; if (act_vec() !== ev) begin n_fail++; $display("FAIL %s strobes_c%0d act=%h exp=%h", tag, k, act_vec(), ev); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_c%0d act=%b exp=1", tag, k, bus.busy); end
      n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_c%0d act=%b exp=0", tag, k, bus.instr_ready); end
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL %s resv_c%0d act=%b exp=0", tag, k, bus.res_valid); end
      rd_val        = (od >= 0) ? DW'(od) : DW'($urandom());
      bus.outdata   = rd_val;
      bus.res_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.res_ready = 1'b0;
    if (op != 3'b011) begin
      n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL %s strobes_gap act=%h exp=0", tag, act_vec()); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_gap act=%b exp=1", tag, bus.busy); end
      n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_gap act=%b exp=0", tag, bus.instr_ready); end
      tick();
    end else begin
      for (int unsigned w = 0; w <= rwait; w++) begin
        n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL %s resv_w%0d act=%b exp=1", tag, w, bus.res_valid); end
        n_tests++; if (bus.res_data !== rd_val) begin n_fail++; $display("FAIL %s resd_w%0d act=%h exp=%h", tag, w, bus.res_data, rd_val); end
        n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL %s strobes_resp act=%h exp=0", tag, act_vec()); end
        n_tests++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_resp act=%b exp=0", tag, bus.instr_ready); end
        if (w == rwait) bus.res_ready = 1'b1;
        tick();
      end
      bus.res_ready = 1'b0;
    end
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_end act=%b exp=1", tag, bus.instr_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_end act=%b exp=0", tag, bus.busy); end
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL %s resv_end act=%b exp=0", tag, bus.res_valid); end
    n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL %s strobes_end act=%h exp=0", tag, act_vec()); end
  endtask

  task automatic test_reset();
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready act=%b exp=1", bus.instr_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy act=%b exp=0", bus.busy); end
    n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL rst_strobes act=%h exp=0", act_vec()); end
    n_tests++; if ({bus.res_valid, bus.res_data, bus.illegal} !== '0) begin n_fail++; $display("FAIL rst_res act=%h exp=0", {bus.res_valid, bus.res_data, bus.illegal}); end
    bus.instr_valid = 1'b1;
    bus.instr       = {3'b001, 3'd5, 2'b00, 8'hA5};
    tick();
    bus.instr_valid = 1'b0;
    n_tests++; if (act_vec() !== exp_vec({3'b001, 3'd5, 2'b00, 8'hA5})) begin n_fail++; $display("FAIL rst_pre_drive act=%h exp=%h", act_vec(), exp_vec({3'b001, 3'd5, 2'b00, 8'hA5})); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (act_vec() !== '0) begin n_fail++; $display("FAIL rst_async_strobes act=%h exp=0", act_vec()); end
    n_tests++; if ({bus.busy, bus.res_valid, bus.illegal, bus.instr_ready} !== 4'b0) begin n_fail++; $display("FAIL rst_async_ctrl act=%b exp=0000", {bus.busy, bus.res_valid, bus.illegal, bus.instr_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready act=%b exp=1", bus.instr_ready); end
    n_tests++; if (act_vec() !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle act=%h/%b exp=0/0", act_vec(), bus.busy); end
  endtask

  task automatic test_ldi();
    exec_one({3'b001, 3'd0, 2'b00, 8'h02}, 0, -1, 1'b0, "ldi");
  endtask

  task automatic test_alu();
    exec_one({3'b010, 3'd2, 2'b00, 8'h00}, 0, -1, 1'b0, "alu");
    exec_one({3'b010, 3'd7, 2'b11, 8'hF6}, 0, -1, 1'b0, "alu_fs");
  endtask

  task automatic test_rd();
    exec_one({3'b011, 3'd2, 2'b00, 8'h00}, 3, 5, 1'b0, "rd_wait3");
    exec_one({3'b011, 3'd6, 2'b01, 8'h3C}, 0, -1, 1'b0, "rd_fast");
  endtask

  task automatic test_illegal_nop();
    exec_one({3'b101, 3'd1, 2'b00, 8'h11}, 0, -1, 1'b0, "illegal");
    exec_one({3'b000, 3'd3, 2'b00, 8'h22}, 0, -1, 1'b0, "nop");
  endtask

  task automatic test_back_to_back();
    exec_one({3'b001, 3'd4, 2'b00, 8'h5A}, 0, -1, 1'b1, "b2b_ldi");
    exec_one({3'b010, 3'd1, 2'b00, 8'h03}, 0, -1, 1'b1, "b2b_alu");
    exec_one({3'b011, 3'd4, 2'b00, 8'h00}, 1, -1, 1'b1, "b2b_rd");
    bus.instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] ins;
    int unsigned sel;
    for (int unsigned i = 0; i < 60; i++) begin
      ins = 16'($urandom());
      sel = $urandom_range(0, 9);
      if (sel == 0)      ins[15:13] = 3'b000;
      else if (sel == 1) ins[15]    = 1'b1;
      else               ins[15:13] = 3'($urandom_range(1, 3));
      exec_one(ins, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)), "rand");
    end
    bus.instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.res_ready   = 1'b0;
    bus.outdata     = '0;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_ldi();
    test_alu();
    test_rd();
    test_illegal_nop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
